seg_scan_sched: RTL and testbench
=================================

Name: seg_scan_sched

Overview:
- Digit-scan scheduler and 74HC595 frame sequencer for the 6-digit 7-segment board.
- Takes six hex nibbles plus decimal-point and blank masks, multiplexes one digit at a time, and serialises a 14-bit {seg, sel} word into the two chained 595s.
- Holds each digit for a programmable dwell.
- Replaces the fixed static pattern source in front of the 595 driver, so the display shows live data.

Parameters:
- SHCP_DIV, 2: sys_clk cycles per half-period of shcp and per stcp high pulse (>=1).
- DWELL_CNT, 50000: sys_clk cycles each digit stays latched (>=2).
- DIG_NUM, 6: digits scanned, fixed at 6 for this board.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- en  in  1  scan enable.
- load  in  1  one-cycle strobe that captures data_in/point_in/blank_in into shadow registers.
- data_in  in  24  nibble i = data_in[4i+3:4i], shown on digit i.
- point_in  in  6  bit i lights the DP of digit i.
- blank_in  in  6  bit i forces digit i dark.
- ds  out  1  595 serial data.
- shcp  out  1  595 shift clock.
- stcp  out  1  595 storage (latch) clock.
- oe  out  1  595 output enable, active-low.
- frame_done  out  1  one-cycle pulse at the end of digit 5's dwell.

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - ds=0, shcp=0, stcp=0, oe=1, frame_done=0.
  - Digit index=0, shadow registers=0, state=IDLE, all counters=0.
  - Reset mid-frame aborts immediately. No partial latch is issued.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DWELL.
- IDLE:
  - en=1 -> LOAD next cycle.
  - en=0 -> stay in IDLE, oe=1.
- LOAD (1 cycle):
  - Decode the active nibble to active-low segments. seg[6:0]=gfedcba, 0 = lit, hex 0-F.
  - seg[7]=~point[i].
  - If blank[i]=1, seg=8'hFF.
  - sel is one-hot active-high, sel[i]=1.
  - Word W={seg[7:0], sel[5:0]}. Bit counter=13.
- SHIFT_LO: ds=W[bit], shcp=0 for SHCP_DIV cycles, then -> SHIFT_HI.
- SHIFT_HI: shcp=1 for SHCP_DIV cycles. ds is held stable.
  - bit>0: bit decrements, -> SHIFT_LO.
  - bit==0: -> LATCH.
- Shift order is W[13] first and W[0] last. Exactly 14 shcp rising edges per digit.
- LATCH:
  - shcp=0, stcp=1 for SHCP_DIV cycles, then stcp=0 -> DWELL.
  - oe goes to 0 on the first cycle after the first LATCH following reset or IDLE.
- DWELL: count DWELL_CNT cycles. At terminal count:
  - Digit index = (index==5) ? 0 : index+1.
  - frame_done=1 for that cycle if index was 5.
  - en=1 -> LOAD. en=0 -> IDLE with oe=1.
- en is sampled only at the end of DWELL and in IDLE. Deasserting en mid-shift completes the current digit.
- Shadow update:
  - load captures into a pending buffer.
  - The pending buffer is copied to the active buffer only when entering LOAD with index 0, so one scan never mixes old and new data.
  - If load coincides with that copy cycle, the new values are used for that scan.
  - Repeated loads within a scan: the last one wins.
- Per-digit period = 1 + 28*SHCP_DIV + SHCP_DIV + DWELL_CNT cycles.

Optional Feature:
- Macro SEG_SCAN_DIM_EN.
- Defined:
  - Adds port bright in 4 (brightness).
  - During DWELL, oe=0 for the first ((bright+1)*DWELL_CNT)>>4 cycles, then oe=1 for the remainder.
  - bright=15 gives full on.
  - bright is sampled at LOAD.
- Undefined:
  - No bright port.
  - oe stays 0 for the whole enabled scan, including shift and latch phases.

Test Plan:
- Reset, then en=1 with SHCP_DIV=1, DWELL_CNT=4 and data 0 -> first 14 ds bits = 1100_0000_000001 (seg 8'hC0, sel 6'b000001). stcp pulses 1 cycle after the 14th shcp rise. oe falls after it.
- load data_in=24'h543210, point_in=6'b000100 -> digit 2 word = {8'h24, 6'b000100}. Digit 0 word = {8'hC0, 6'b000001} (DP off).
- blank_in=6'b100000 -> digit 5 word = {8'hFF, 6'b100000}. frame_done pulses once per 6 digits, every 6*(1+29+4)=204 cycles.
- load pulsed mid-scan during digit 3 -> digits 3-5 keep old data and the new data appears from digit 0. A load in the same cycle as the index-0 LOAD takes effect immediately.
- sys_rst asserted during SHIFT_HI of bit 7 -> next cycle all outputs are at reset values, no stcp pulse, and the scan restarts at digit 0.
- Dimming, with SEG_SCAN_DIM_EN, DWELL_CNT=16, bright=3 -> oe=0 for 4 DWELL cycles and 1 for 12.

Source files
------------

// File: rtl/seg_scan_sched.sv
// Digit-scan scheduler and 74HC595 frame sequencer for a 6-digit 7-segment board.
// Define SEG_SCAN_DIM_EN to add a 4-bit bright port that PWMs oe within each dwell.
module seg_scan_sched #(
  parameter int SHCP_DIV  = 2,
  parameter int DWELL_CNT = 50000,
  parameter int DIG_NUM   = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic        load,
  input  logic [23:0] data_in,
  input  logic [5:0]  point_in,
  input  logic [5:0]  blank_in,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  bright,
`endif
  output logic        ds,
  output logic        shcp,
  output logic        stcp,
  output logic        oe,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DWELL_CNT + SHCP_DIV + 1) + 1;
  localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SHCP_DIV - 1);
  localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_CNT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIG_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_DWELL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_bit;
  logic [3:0]       w_bit_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [13:0]      r_word;
  logic [13:0]      w_word_nxt;
  logic [13:0]      w_word_new;
  logic             r_armed;
  logic             w_armed_nxt;

  logic [23:0]      r_pend_data;
  logic [5:0]       r_pend_point;
  logic [5:0]       r_pend_blank;
  logic [23:0]      r_act_data;
  logic [5:0]       r_act_point;
  logic [5:0]       r_act_blank;
  logic [23:0]      w_src_data;
  logic [5:0]       w_src_point;
  logic [5:0]       w_src_blank;
  logic             w_copy;

  logic             r_ds;
  logic             r_shcp;
  logic             r_stcp;
  logic             r_oe;
  logic             r_fd;
  logic             w_ds_nxt;
  logic             w_shcp_nxt;
  logic             w_stcp_nxt;
  logic             w_oe_nxt;
  logic             w_fd_nxt;

`ifdef SEG_SCAN_DIM_EN
  logic [CNT_W-1:0] r_on;
  logic [CNT_W-1:0] w_on_new;

  assign w_on_new = CNT_W'(((32'(bright) + 32'd1) * 32'(DWELL_CNT)) >> 4);
`endif

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [13:0] build_word(input logic [3:0] nib, input logic pt,
                                             input logic bl, input logic [2:0] idx);
    logic [7:0] seg;
    logic [5:0] sel;
    seg = bl ? 8'hFF : {~pt, seg_decode(nib)};
    sel = 6'b000001 << idx;
    return {seg, sel};
  endfunction

  // The index-0 LOAD is the only point where a new frame's data becomes visible;
  // a load strobe in that same cycle bypasses the pending buffer.
  always_comb begin
    w_copy      = (r_state == S_LOAD) && (r_idx == 3'd0);
    w_src_data  = r_act_data;
    w_src_point = r_act_point;
    w_src_blank = r_act_blank;
    if (w_copy) begin
      w_src_data  = load ? data_in  : r_pend_data;
      w_src_point = load ? point_in : r_pend_point;
      w_src_blank = load ? blank_in : r_pend_blank;
    end
    w_word_new = build_word(w_src_data[{r_idx, 2'b00} +: 4], w_src_point[r_idx],
                            w_src_blank[r_idx], r_idx);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_idx_nxt   = r_idx;
    w_armed_nxt = r_armed;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        w_armed_nxt = 1'b0;
        w_cnt_nxt   = '0;
        if (en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_word_nxt  = w_word_new;
        w_bit_nxt   = 4'd13;
        w_cnt_nxt   = '0;
        w_state_nxt = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (r_cnt == SH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT_HI;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (r_cnt == SH_LAST) begin
          w_cnt_nxt = '0;
          if (r_bit == 4'd0) begin
            w_state_nxt = S_LATCH;
          end else begin
            w_bit_nxt   = r_bit - 4'd1;
            w_state_nxt = S_SHIFT_LO;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (r_cnt == SH_LAST) begin
          w_cnt_nxt   = '0;
          w_armed_nxt = 1'b1;
          w_state_nxt = S_DWELL;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DWELL: begin
        if (r_cnt == DW_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
          if (en) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_armed_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_armed_nxt = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pin values are registered from the next-state view so the 595 clocks never glitch.
  always_comb begin
    w_ds_nxt = 1'b0;
    if ((w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI)) begin
      w_ds_nxt = w_word_nxt[w_bit_nxt];
    end
    w_shcp_nxt = (w_state_nxt == S_SHIFT_HI);
    w_stcp_nxt = (w_state_nxt == S_LATCH);
    w_fd_nxt   = (w_state_nxt == S_DWELL) && (w_cnt_nxt == DW_LAST) && (w_idx_nxt == IDX_LAST);
    w_oe_nxt   = ~w_armed_nxt;
`ifdef SEG_SCAN_DIM_EN
    if (w_armed_nxt && (w_state_nxt == S_DWELL) && (w_cnt_nxt >= r_on)) w_oe_nxt = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_armed      <= 1'b0;
      r_pend_data  <= '0;
      r_pend_point <= '0;
      r_pend_blank <= '0;
      r_act_data   <= '0;
      r_act_point  <= '0;
      r_act_blank  <= '0;
      r_ds         <= 1'b0;
      r_shcp       <= 1'b0;
      r_stcp       <= 1'b0;
      r_oe         <= 1'b1;
      r_fd         <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      r_on         <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
      r_armed <= w_armed_nxt;
      if (load) begin
        r_pend_data  <= data_in;
        r_pend_point <= point_in;
        r_pend_blank <= blank_in;
      end
      if (w_copy) begin
        r_act_data  <= w_src_data;
        r_act_point <= w_src_point;
        r_act_blank <= w_src_blank;
      end
      r_ds   <= w_ds_nxt;
      r_shcp <= w_shcp_nxt;
      r_stcp <= w_stcp_nxt;
      r_oe   <= w_oe_nxt;
      r_fd   <= w_fd_nxt;
`ifdef SEG_SCAN_DIM_EN
      if (r_state == S_LOAD) r_on <= w_on_new;
`endif
    end
  end

  assign ds         = r_ds;
  assign shcp       = r_shcp;
  assign stcp       = r_stcp;
  assign oe         = r_oe;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Bench for seg_scan_sched: directed frames plus randomized loads/enables against a
// cycle-offset model of each digit period.
module tb_seg_scan_sched;

  localparam int D  = 1;
  localparam int DW = 4;
  localparam int P  = 1 + 29 * D + DW;
  localparam int T_SH_END = 28 * D;
  localparam int T_LA_END = 29 * D;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        load;
  logic [23:0] data_in;
  logic [5:0]  point_in;
  logic [5:0]  blank_in;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]  bright;
`endif
  logic        ds;
  logic        shcp;
  logic        stcp;
  logic        oe;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg_scan_sched #(.SHCP_DIV(D), .DWELL_CNT(DW), .DIG_NUM(6)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .load      (load),
    .data_in   (data_in),
    .point_in  (point_in),
    .blank_in  (blank_in),
`ifdef SEG_SCAN_DIM_EN
    .bright    (bright),
`endif
    .ds        (ds),
    .shcp      (shcp),
    .stcp      (stcp),
    .oe        (oe),
    .frame_done(frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  // Lit-high gfedcba patterns for hex 0-F; the board wants them inverted.
  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [23:0] m_pend_d, m_act_d;
  logic [5:0]  m_pend_p, m_act_p, m_pend_b, m_act_b;
  int          m_idx;
  bit          m_first;
  int          fd_prev;

  logic [23:0] pl_d [6];
  logic [5:0]  pl_p [6];
  logic [5:0]  pl_b [6];
  int          ld_at [6];
  int          en_at [6];
  logic [13:0] caps [6];

  function automatic logic [13:0] exp_word(input int idx);
    logic [3:0] nib;
    logic [7:0] seg;
    logic [5:0] sel;
    nib = m_act_d[idx*4 +: 4];
    seg = {~m_act_p[idx], ~lit_tab[nib]};
    if (m_act_b[idx]) seg = 8'hFF;
    sel = 6'd0;
    sel[idx] = 1'b1;
    return {seg, sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_pend_d = '0; m_pend_p = '0; m_pend_b = '0;
    m_act_d  = '0; m_act_p  = '0; m_act_b  = '0;
    m_idx = 0;
    m_first = 1'b1;
    fd_prev = -1;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_ds"},   32'(ds),         32'd0);
    chk({tag, "_shcp"}, 32'(shcp),       32'd0);
    chk({tag, "_stcp"}, 32'(stcp),       32'd0);
    chk({tag, "_oe"},   32'(oe),         32'd1);
    chk({tag, "_fd"},   32'(frame_done), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_shcp", 32'(shcp),       32'd0);
      chk("idle_stcp", 32'(stcp),       32'd0);
      chk("idle_oe",   32'(oe),         32'd1);
      chk("idle_fd",   32'(frame_done), 32'd0);
      tick();
    end
  endtask

  task automatic start();
    en = 1'b1;
    tick();
  endtask

  // One digit period, checked cycle by cycle from its offset t (t=0 is the LOAD cycle).
  task automatic step_digit(input int load_t, input logic [23:0] nd, input logic [5:0] np,
                            input logic [5:0] nb, input int en_t, input logic en_v,
                            input int abort_t, output logic [13:0] cap);
    int edges;
    logic prev_sh;
    logic [13:0] w;
    int on;
    int j;
    int k;
    logic e_shcp, e_stcp, e_oe, e_fd;
    cap = '0; edges = 0; prev_sh = 1'b0; w = '0; on = DW;
`ifdef SEG_SCAN_DIM_EN
    bright = 4'($urandom_range(0, 15));
    on = ((int'(bright) + 1) * DW) >> 4;
`endif
    for (int t = 0; t < P; t++) begin
      if (t == abort_t) begin
        sys_rst = 1'b1;
        en = 1'b0;
        tick();
        model_reset();
        return;
      end
      e_shcp = 1'b0;
      if (t >= 1 && t <= T_SH_END) begin
        j = t - 1;
        e_shcp = ((j % (2 * D)) >= D);
        chk($sformatf("ds_d%0d_t%0d", m_idx, t), 32'(ds), 32'(w[13 - j / (2 * D)]));
      end
      e_stcp = (t > T_SH_END && t <= T_LA_END);
      if (t <= T_LA_END) begin
        e_oe = m_first;
      end else begin
        k = t - T_LA_END - 1;
        e_oe = (k < on) ? 1'b0 : 1'b1;
      end
      e_fd = (t == P - 1) && (m_idx == 5);
      chk($sformatf("shcp_d%0d_t%0d", m_idx, t), 32'(shcp), 32'(e_shcp));
      chk($sformatf("stcp_d%0d_t%0d", m_idx, t), 32'(stcp), 32'(e_stcp));
      chk($sformatf("oe_d%0d_t%0d", m_idx, t),   32'(oe),   32'(e_oe));
      chk($sformatf("fd_d%0d_t%0d", m_idx, t),   32'(frame_done), 32'(e_fd));
      if (e_fd && frame_done === 1'b1) begin
        if (fd_prev >= 0) chk("fd_period", 32'(cyc - fd_prev), 32'(6 * P));
        fd_prev = cyc;
      end
      if (shcp === 1'b1 && prev_sh === 1'b0) begin
        cap = {cap[12:0], ds};
        edges++;
      end
      prev_sh = shcp;
      if (t == load_t) begin
        load = 1'b1; data_in = nd; point_in = np; blank_in = nb;
      end
      if (t == en_t) en = en_v;
      tick();
      load = 1'b0;
      if (t == load_t) begin
        m_pend_d = nd; m_pend_p = np; m_pend_b = nb;
      end
      if (t == 0) begin
        if (m_idx == 0) begin
          m_act_d = m_pend_d; m_act_p = m_pend_p; m_act_b = m_pend_b;
        end
        w = exp_word(m_idx);
      end
    end
    chk($sformatf("edges_d%0d", m_idx), 32'(edges), 32'd14);
    m_idx = (m_idx + 1) % 6;
    m_first = 1'b0;
    if (!en) begin
      m_first = 1'b1;
      fd_prev = -1;
    end
  endtask

  task automatic clear_plan();
    for (int d = 0; d < 6; d++) begin
      ld_at[d] = -1; en_at[d] = -1;
      pl_d[d] = '0; pl_p[d] = '0; pl_b[d] = '0;
      caps[d] = '0;
    end
  endtask

  task automatic run_frame();
    logic [13:0] tmp;
    for (int d = m_idx; d < 6; d++) begin
      step_digit(ld_at[d], pl_d[d], pl_p[d], pl_b[d], en_at[d], 1'b0, -1, tmp);
      caps[d] = tmp;
      if (!en) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] tmp;
    sys_rst = 1'b1; en = 1'b0; load = 1'b0;
    data_in = '0; point_in = '0; blank_in = '0;
`ifdef SEG_SCAN_DIM_EN
    bright = 4'd15;
`endif
    model_reset();
    clear_plan();
    repeat (3) tick();
    check_reset_pins("rst");
    sys_rst = 1'b0;
    idle_cycles(2);

    start();
    run_frame();
    chk("f1_d0_word", 32'(caps[0]), 32'({8'hC0, 6'b000001}));
    chk("f1_d3_word", 32'(caps[3]), 32'({8'hC0, 6'b001000}));

    clear_plan();
    ld_at[0] = 0; pl_d[0] = 24'h543210; pl_p[0] = 6'b000100; pl_b[0] = 6'b000000;
    ld_at[3] = 5; pl_d[3] = 24'h543210; pl_p[3] = 6'b000100; pl_b[3] = 6'b100000;
    run_frame();
    chk("f2_d0_word", 32'(caps[0]), 32'({8'hC0, 6'b000001}));
    chk("f2_d1_word", 32'(caps[1]), 32'({8'hF9, 6'b000010}));
    chk("f2_d2_word", 32'(caps[2]), 32'({8'h24, 6'b000100}));
    chk("f2_d5_word", 32'(caps[5]), 32'({8'h92, 6'b100000}));

    clear_plan();
    en_at[5] = 10;
    run_frame();
    chk("f3_d0_word", 32'(caps[0]), 32'({8'hC0, 6'b000001}));
    chk("f3_d5_word", 32'(caps[5]), 32'({8'hFF, 6'b100000}));
    idle_cycles(3);

    start();
    step_digit(-1, '0, '0, '0, -1, 1'b0, 1 + 13 * D, tmp);
    check_reset_pins("abort");
    tick();
    check_reset_pins("abort_hold");
    sys_rst = 1'b0;
    idle_cycles(3);
    start();
    clear_plan();
    run_frame();
    chk("f4_d0_word", 32'(caps[0]), 32'({8'hC0, 6'b000001}));
    chk("f4_d5_word", 32'(caps[5]), 32'({8'hC0, 6'b100000}));

    for (int f = 0; f < 8; f++) begin
      clear_plan();
      for (int d = 0; d < 6; d++) begin
        if ($urandom_range(0, 2) == 0) begin
          ld_at[d] = (d == 0 && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, P - 1));
          pl_d[d] = 24'($urandom);
          pl_p[d] = 6'($urandom);
          pl_b[d] = 6'($urandom) & 6'($urandom);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        en_at[$urandom_range(m_idx, 5)] = int'($urandom_range(0, P - 1));
      end
      run_frame();
      if (!en) begin
        idle_cycles(int'($urandom_range(1, 3)));
        start();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
